// File: rtl/cpu_types.sv
// Shared CPU type definitions: memory access sizes and arbiter states.
package cpu_types;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;
    localparam logic [XLEN-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        MASK_BYTE = 2'b00,
        MASK_HALF = 2'b01,
        MASK_WORD = 2'b10
    } memory_mask_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_FETCH = 2'b01,
        ARB_DATA  = 2'b10
    } arb_state_t;

endpackage

// File: rtl/memory_lane_align.sv
// Combinational byte-lane placement for stores, lane extraction/extension for loads,
// and misalignment detection for the data requester.
module memory_lane_align
    import cpu_types::*;
(
    input  memory_mask_t    st_mask,
    input  logic [1:0]      st_addr,
    input  logic [XLEN-1:0] st_wdata,
    output logic [XLEN-1:0] st_lane_wdata,
    output logic [BE_W-1:0] st_byte_en,
    output logic            st_misaligned,
    input  memory_mask_t    ld_mask,
    input  logic [1:0]      ld_addr,
    input  logic            ld_sign_ext,
    input  logic [XLEN-1:0] ld_word,
    output logic [XLEN-1:0] ld_rdata
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        st_lane_wdata = st_wdata;
        st_byte_en    = 4'b1111;
        st_misaligned = 1'b0;
        case (st_mask)
            MASK_BYTE: begin
                st_lane_wdata = {4{st_wdata[7:0]}};
                st_byte_en    = 4'b0001 << st_addr;
            end
            MASK_HALF: begin
                st_lane_wdata = {2{st_wdata[15:0]}};
                st_byte_en    = st_addr[1] ? 4'b1100 : 4'b0011;
                st_misaligned = st_addr[0];
            end
            default: st_misaligned = |st_addr;
        endcase
    end

    always_comb begin
        shifted  = ld_word >> {ld_addr, 3'b000};
        ld_rdata = ld_word;
        case (ld_mask)
            MASK_BYTE: ld_rdata = {{24{ld_sign_ext & shifted[7]}}, shifted[7:0]};
            MASK_HALF: ld_rdata = {{16{ld_sign_ext & shifted[15]}}, shifted[15:0]};
            default:   ld_rdata = ld_word;
        endcase
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking instead of data priority.
module memory_arbiter
    import cpu_types::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ready,
    output logic [XLEN-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  memory_mask_t    dm_mask,
    input  logic            dm_sign_ext,
    output logic            dm_ready,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_misaligned,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [BE_W-1:0] mem_byte_en,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready
);

    arb_state_t      state_q, state_d;
    logic            grant_if, grant_dm, prefer_dm;
    memory_mask_t    mask_q;
    logic [1:0]      addr_lo_q;
    logic            sign_ext_q;
    logic [XLEN-1:0] st_lane_wdata, ld_rdata;
    logic [BE_W-1:0] st_byte_en;
    logic            st_misaligned;

    memory_lane_align u_align (
        .st_mask       (dm_mask),
        .st_addr       (dm_addr[1:0]),
        .st_wdata      (dm_wdata),
        .st_lane_wdata (st_lane_wdata),
        .st_byte_en    (st_byte_en),
        .st_misaligned (st_misaligned),
        .ld_mask       (mask_q),
        .ld_addr       (addr_lo_q),
        .ld_sign_ext   (sign_ext_q),
        .ld_word       (mem_rdata),
        .ld_rdata      (ld_rdata)
    );

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    // Set when the data side was served most recently; reset value lets fetch win the first tie.
    logic last_dm_q;

    assign prefer_dm = !if_req || !last_dm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_dm_q <= 1'b1;
        else if (grant_dm || dm_misaligned)
            last_dm_q <= 1'b1;
        else if (grant_if)
            last_dm_q <= 1'b0;
    end
`else
    assign prefer_dm = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ARB_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        grant_if      = 1'b0;
        grant_dm      = 1'b0;
        if_ready      = 1'b0;
        if_rdata      = '0;
        dm_ready      = 1'b0;
        dm_rdata      = '0;
        dm_misaligned = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (dm_req && prefer_dm) begin
                    // Misaligned requests are answered on the spot and never reach memory.
                    if (st_misaligned) begin
                        dm_ready      = 1'b1;
                        dm_misaligned = 1'b1;
                    end else begin
                        state_d  = ARB_DATA;
                        grant_dm = 1'b1;
                    end
                end else if (if_req) begin
                    state_d  = ARB_FETCH;
                    grant_if = 1'b1;
                end
            end
            ARB_FETCH: begin
                if (mem_ready) begin
                    if_ready = 1'b1;
                    if_rdata = mem_rdata;
                    // A misaligned data request waiting here is answered from IDLE next cycle.
                    if (dm_req && !st_misaligned) begin
                        state_d  = ARB_DATA;
                        grant_dm = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            ARB_DATA: begin
                if (mem_ready) begin
                    dm_ready = 1'b1;
                    if (!mem_we)
                        dm_rdata = ld_rdata;
                    if (if_req) begin
                        state_d  = ARB_FETCH;
                        grant_if = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_byte_en <= '0;
            mask_q      <= MASK_BYTE;
            addr_lo_q   <= 2'b00;
            sign_ext_q  <= 1'b0;
        end else begin
            mem_req <= (state_d != ARB_IDLE);
            if (grant_dm) begin
                mem_we      <= dm_we;
                mem_addr    <= dm_addr & WORD_ALIGN_MASK;
                mem_wdata   <= dm_we ? st_lane_wdata : '0;
                mem_byte_en <= st_byte_en;
                mask_q      <= dm_mask;
                addr_lo_q   <= dm_addr[1:0];
                sign_ext_q  <= dm_sign_ext;
            end else if (grant_if) begin
                mem_we      <= 1'b0;
                mem_addr    <= if_addr & WORD_ALIGN_MASK;
                mem_wdata   <= '0;
                mem_byte_en <= 4'b1111;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed cases plus concurrent random fetch/data traffic.
module tb_memory_arbiter;
    import cpu_types::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         if_req, if_ready, dm_req, dm_we, dm_sign_ext, dm_ready, dm_misaligned;
    logic [31:0]  if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    memory_mask_t dm_mask;
    logic         mem_req, mem_we, mem_ready;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [3:0]   mem_byte_en;

    memory_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_mask(dm_mask), .dm_sign_ext(dm_sign_ext), .dm_ready(dm_ready),
        .dm_rdata(dm_rdata), .dm_misaligned(dm_misaligned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; logic mis; } dm_exp_t;

    logic [31:0] mem_words [0:255];
    logic [7:0]  ref_bytes [0:1023];
    logic [31:0] if_exp_q [$];
    dm_exp_t     dm_exp_q [$];
    int          done_who [$];
    int          done_cyc [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          min_wait = 0;
    int          max_wait = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 'h40) return 32'h00A00093;
        if (i == 'h80) return 32'h80FF1234;
        return 32'h13579BDF ^ (32'(i) * 32'h01010107);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no ready within cycle budget", name);
    endtask

    // Reference: byte-addressed little-endian memory, accesses applied in issue order.
    function automatic void model_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                     input memory_mask_t mask, input logic sx,
                                     output logic [31:0] rd, output logic mis);
        int size;
        int a;
        size = (mask == MASK_BYTE) ? 1 : (mask == MASK_HALF) ? 2 : 4;
        a    = int'(addr[9:0]);
        rd   = '0;
        mis  = (a % size) != 0;
        if (mis) return;
        if (we) begin
            for (int i = 0; i < size; i++) ref_bytes[a + i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) rd = rd | (32'(ref_bytes[a + i]) << (8*i));
            if (sx && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFFFFFF << (8*size));
        end
    endfunction

    task automatic push_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input memory_mask_t mask, input logic sx);
        dm_exp_t e;
        model_dm(we, addr, wdata, mask, sx, e.rdata, e.mis);
        dm_exp_q.push_back(e);
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        int t;
        if_addr = addr;
        if_req  = 1'b1;
        if_exp_q.push_back(init_word(int'(addr[9:2])));
        t = 0;
        do begin @(negedge clk); t++; end while (!if_ready && t < 200);
        if (!if_ready) timeout_fail("fetch_timeout");
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input memory_mask_t mask, input logic sx,
                           output logic [31:0] got, output logic got_mis);
        int t;
        dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_mask = mask; dm_sign_ext = sx;
        dm_req = 1'b1;
        push_dm(we, addr, wdata, mask, sx);
        got = '0; got_mis = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!dm_ready && t < 200);
        if (!dm_ready) timeout_fail("data_timeout");
        else begin got = dm_rdata; got_mis = dm_misaligned; end
        @(posedge clk); #1;
        dm_req = 1'b0;
    endtask

    // External memory: random wait states, byte-enabled writes committed at completion.
    initial begin
        int  wait_cnt;
        bit  active;
        int  idx;
        active = 0; wait_cnt = 0; mem_ready = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || !mem_req) begin
                mem_ready = 1'b0;
                active = 0;
            end else begin
                if (!active) begin
                    active = 1;
                    wait_cnt = int'($urandom_range(max_wait, min_wait));
                end
                if (wait_cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_words[mem_addr[9:2]];
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt--;
                end
            end
            @(negedge clk);
            if (rst_n && mem_req && mem_ready) begin
                idx = int'(mem_addr[9:2]);
                if (mem_we)
                    for (int b = 0; b < 4; b++)
                        if (mem_byte_en[b]) mem_words[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                active = 0;
            end
        end
    end

    // Monitor: pops the expected response whenever a ready pulse is presented.
    initial begin
        dm_exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && if_ready) begin
                if (if_exp_q.size() == 0) timeout_fail("if_ready_unexpected");
                else chk("if_rdata", if_rdata, if_exp_q.pop_front());
                done_who.push_back(0);
                done_cyc.push_back(cyc);
            end
            if (rst_n && dm_ready) begin
                if (dm_exp_q.size() == 0) timeout_fail("dm_ready_unexpected");
                else begin
                    e = dm_exp_q.pop_front();
                    chk("dm_rdata", dm_rdata, e.rdata);
                    chk("dm_misaligned", 32'(dm_misaligned), 32'(e.mis));
                end
                done_who.push_back(1);
                done_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        m;
        logic [31:0] w;
        int          base;
        int          exp_first;

        for (int i = 0; i < 256; i++) begin
            w = init_word(i);
            mem_words[i] = w;
            for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = w[8*b +: 8];
        end
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        dm_mask = MASK_WORD; dm_sign_ext = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_byte_en", 32'(mem_byte_en), 0);
        chk("rst_if_ready", 32'(if_ready), 0);
        chk("rst_dm_ready", 32'(dm_ready), 0);
        chk("rst_dm_misaligned", 32'(dm_misaligned), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Fetch with zero-wait memory: mem_req and if_ready one cycle after the request.
        if_addr = 32'h100; if_req = 1'b1;
        if_exp_q.push_back(32'h00A00093);
        @(negedge clk);
        chk("fetch_n_mem_req", 32'(mem_req), 0);
        @(negedge clk);
        chk("fetch_mem_req", 32'(mem_req), 1);
        chk("fetch_mem_addr", mem_addr, 32'h100);
        chk("fetch_byte_en", 32'(mem_byte_en), 32'hF);
        chk("fetch_mem_we", 32'(mem_we), 0);
        chk("fetch_if_ready", 32'(if_ready), 1);
        chk("fetch_if_rdata", if_rdata, 32'h00A00093);
        @(posedge clk); #1;
        if_req = 1'b0;

        // Loads from word 0x200 = 0x80FF1234.
        do_data(0, 32'h201, 0, MASK_BYTE, 0, r, m);  chk("ld_bu_201", r, 32'h00000012);
        do_data(0, 32'h203, 0, MASK_BYTE, 1, r, m);  chk("ld_bs_203", r, 32'hFFFFFF80);
        do_data(0, 32'h203, 0, MASK_BYTE, 0, r, m);  chk("ld_bu_203", r, 32'h00000080);
        do_data(0, 32'h202, 0, MASK_HALF, 1, r, m);  chk("ld_hs_202", r, 32'hFFFF80FF);
        do_data(0, 32'h200, 0, MASK_WORD, 1, r, m);  chk("ld_w_200", r, 32'h80FF1234);

        // Byte store to 0x203.
        dm_we = 1; dm_addr = 32'h203; dm_wdata = 32'h000000AB; dm_mask = MASK_BYTE; dm_sign_ext = 0;
        dm_req = 1'b1;
        push_dm(1, 32'h203, 32'h000000AB, MASK_BYTE, 0);
        @(negedge clk);
        @(negedge clk);
        chk("st_mem_addr", mem_addr, 32'h200);
        chk("st_mem_wdata", mem_wdata, 32'hABABABAB);
        chk("st_byte_en", 32'(mem_byte_en), 32'h8);
        chk("st_mem_we", 32'(mem_we), 1);
        chk("st_dm_ready", 32'(dm_ready), 1);
        @(posedge clk); #1;
        dm_req = 1'b0;
        do_data(0, 32'h200, 0, MASK_WORD, 0, r, m);  chk("ld_after_st", r, 32'hABFF1234);

        // Misaligned word load: answered in the request cycle, no memory access.
        dm_we = 0; dm_addr = 32'h102; dm_mask = MASK_WORD; dm_req = 1'b1;
        push_dm(0, 32'h102, 0, MASK_WORD, 0);
        @(negedge clk);
        chk("mis_dm_ready", 32'(dm_ready), 1);
        chk("mis_flag", 32'(dm_misaligned), 1);
        chk("mis_mem_req", 32'(mem_req), 0);
        @(posedge clk); #1;
        dm_req = 1'b0;
        @(negedge clk);
        chk("mis_mem_req_after", 32'(mem_req), 0);
        @(posedge clk); #1;

        // Contention with two wait cycles: order and back-to-back spacing.
        min_wait = 2; max_wait = 2;
        base = done_who.size();
        fork
            do_fetch(32'h040);
            begin
                logic [31:0] r2;
                logic        m2;
                do_data(0, 32'h210, 0, MASK_WORD, 0, r2, m2);
            end
        join
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        exp_first = 0;
`else
        exp_first = 1;
`endif
        if (done_who.size() >= base + 2) begin
            chk("contend_first", 32'(done_who[base]), 32'(exp_first));
            chk("contend_second", 32'(done_who[base+1]), 32'(1 - exp_first));
            chk("contend_b2b_gap", 32'(done_cyc[base+1] - done_cyc[base]), 3);
        end else timeout_fail("contend_completions");

        // Reset while DATA waits on memory: abandoned, no ready pulse.
        min_wait = 20; max_wait = 20;
        dm_we = 0; dm_addr = 32'h240; dm_mask = MASK_WORD; dm_sign_ext = 0; dm_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstmid_busy", 32'(mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_mem_req", 32'(mem_req), 0);
        chk("rstmid_dm_ready", 32'(dm_ready), 0);
        dm_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        min_wait = 0; max_wait = 0;
        base = done_who.size();
        do_fetch(32'h004);
        chk("rstmid_refetch", 32'(done_who.size() - base), 1);

        // Random concurrent traffic.
        min_wait = 0; max_wait = 3;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
                    do_fetch({22'd0, 8'($urandom_range(127, 0)), 2'b00});
                end
            end
            begin
                logic [31:0] r3;
                logic        m3;
                for (int i = 0; i < 100; i++) begin
                    repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
                    do_data(1'($urandom_range(1, 0)), 32'h200 + 32'($urandom_range(255, 0)),
                            $urandom, memory_mask_t'($urandom_range(2, 0)),
                            1'($urandom_range(1, 0)), r3, m3);
                end
            end
        join
        repeat (3) @(negedge clk);
        chk("if_queue_drained", 32'(if_exp_q.size()), 0);
        chk("dm_queue_drained", 32'(dm_exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
